pipeline_ex_stage: RTL and testbench

Parametrised execute stage for the pipelined CPU. It computes branch target and PC+4, performs ALU operations in one cycle, and runs multiply/divide (RV32M semantics) over multiple cycles. It sits between the ID/EX and EX/MEM boundaries and owns a registered output slot with valid/ready handshakes on both sides, so it can stall upstream while a multi-cycle operation runs. A flush input discards in-flight work on branch mispredict.

---
 rtl/pipeline_ex_pkg.sv | 35 +++
 rtl/pipeline_ex_stage_divider.sv | 102 ++++++++++
 rtl/pipeline_ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ex_pkg.sv
// pipeline_ex_pkg: shared encodings for the execute stage (ALU codes, MD ops, FSM states).
// Rev 1.0
`default_nettype none

package pipeline_ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } ex_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_ex_stage_divider.sv
// ex_divider: iterative restoring divider on magnitudes, one quotient bit per cycle.
// Rev 1.0
`default_nettype none

module ex_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_ack,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int c_cw = $clog2(XLEN + 1);

  logic            r_busy;
  logic [c_cw-1:0] r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_ovf;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_n;
  logic [XLEN-1:0] w_quo_n;

  assign w_a_neg = i_signed && i_dividend[XLEN-1];
  assign w_b_neg = i_signed && i_divisor[XLEN-1];
  assign w_a_mag = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_sub    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = !w_sub[XLEN];
  assign w_rem_n  = w_ge ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_n  = {r_quo[XLEN-2:0], w_ge};

  // Last quotient bit is resolved combinationally so the result is ready XLEN cycles after start.
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == c_cw'(1));
  assign o_quotient  = r_div0 ? {XLEN{1'b1}} :
                       r_ovf  ? {1'b1, {(XLEN-1){1'b0}}} :
                       r_neg_q ? (~w_quo_n + 1'b1) : w_quo_n;
  assign o_remainder = r_ovf   ? '0 :
                       r_neg_r ? (~w_rem_n + 1'b1) : w_rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= c_cw'(XLEN);
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_dvs   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_div0  <= (i_divisor == '0);
      r_ovf   <= i_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (i_divisor == {XLEN{1'b1}});
    end else if (r_busy) begin
      if (r_cnt > c_cw'(1)) begin
        r_quo <= w_quo_n;
        r_rem <= w_rem_n;
        r_cnt <= r_cnt - 1'b1;
      end else if (i_ack) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_ex_stage.sv
// pipeline_ex_stage: execute stage with 1-cycle ALU, multi-cycle MUL/DIV and a handshaked output slot.
// Rev 1.0
`default_nettype none

module pipeline_ex_stage
  import pipeline_ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            alu_src_b_in,
  input  logic [3:0]      alu_ctrl_in,
  input  logic            md_en_in,
  input  logic [2:0]      md_op_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_target_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            zero_out
);

  localparam int c_shw = $clog2(XLEN);
  localparam int c_mcw = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [c_mcw-1:0] c_mul_init = c_mcw'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  ex_state_e        r_state;
  logic [c_mcw-1:0] r_mul_cnt;
  logic [2:0]       r_md_op;
  logic [XLEN-1:0]  r_mul_a;
  logic [XLEN-1:0]  r_mul_b;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_pc_target;
  logic [XLEN-1:0]  r_pc4;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rs2;

  logic             w_slot_free;
  logic             w_accept;
  logic [XLEN-1:0]  w_b;
  logic [c_shw-1:0] w_shamt;
  logic [XLEN-1:0]  w_alu;
  logic [XLEN-1:0]  w_mul_res;
  logic [XLEN-1:0]  w_mul_now;
  logic             w_div_start;
  logic             w_div_ack;
  logic             w_div_busy;
  logic             w_div_done;
  logic [XLEN-1:0]  w_div_q;
  logic [XLEN-1:0]  w_div_r;
  logic [XLEN-1:0]  w_div_res;

  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    a_ext = {{XLEN{a[XLEN-1] && (op == MD_MULH || op == MD_MULHSU)}}, a};
    b_ext = {{XLEN{b[XLEN-1] && (op == MD_MULH)}}, b};
    prod  = a_ext * b_ext;
    return (op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !rst && (r_state == ST_IDLE) && !flush && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  assign w_b     = alu_src_b_in ? imm_in : rs2_in;
  assign w_shamt = w_b[c_shw-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_ctrl_in)
      ALU_ADD:  w_alu = rs1_in + w_b;
      ALU_SUB:  w_alu = rs1_in - w_b;
      ALU_SLL:  w_alu = rs1_in << w_shamt;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_in) < $signed(w_b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, rs1_in < w_b};
      ALU_XOR:  w_alu = rs1_in ^ w_b;
      ALU_SRL:  w_alu = rs1_in >> w_shamt;
      ALU_SRA:  w_alu = $signed(rs1_in) >>> w_shamt;
      ALU_OR:   w_alu = rs1_in | w_b;
      ALU_AND:  w_alu = rs1_in & w_b;
      default:  w_alu = '0;
    endcase
  end

  assign w_mul_res = mul_result(r_md_op, r_mul_a, r_mul_b);
  assign w_mul_now = mul_result(md_op_in, rs1_in, rs2_in);

  assign w_div_start = w_accept && md_en_in && md_op_in[2];
  assign w_div_ack   = (r_state == ST_DIV_BUSY) && w_div_busy && w_div_done && w_slot_free && !flush;
  // REM/REMU have op[1] set; DIV/DIVU do not.
  assign w_div_res   = r_md_op[1] ? w_div_r : w_div_q;

  ex_divider #(.XLEN(XLEN)) u_divider (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_start     (w_div_start),
    .i_signed    (!md_op_in[0]),
    .i_dividend  (rs1_in),
    .i_divisor   (rs2_in),
    .i_ack       (w_div_ack),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mul_cnt   <= '0;
      r_md_op     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_out_valid <= 1'b0;
      r_pc_target <= '0;
      r_pc4       <= '0;
      r_alu       <= '0;
      r_rs2       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_state     <= ST_IDLE;
      r_mul_cnt   <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pc_target <= pc_in + imm_in;
            r_pc4       <= pc_in + XLEN'(4);
            r_rs2       <= rs2_in;
            r_md_op     <= md_op_in;
            if (!md_en_in) begin
              r_alu       <= w_alu;
              r_out_valid <= 1'b1;
            end else if (md_op_in[2]) begin
              r_state <= ST_DIV_BUSY;
            end else if (MUL_LAT == 1) begin
              r_alu       <= w_mul_now;
              r_out_valid <= 1'b1;
            end else begin
              r_state   <= ST_MUL_BUSY;
              r_mul_cnt <= c_mul_init;
              r_mul_a   <= rs1_in;
              r_mul_b   <= rs2_in;
            end
          end
        end
        ST_MUL_BUSY: begin
          if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
          end else if (w_slot_free) begin
            r_alu       <= w_mul_res;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_DIV_BUSY: begin
          if (w_div_ack) begin
            r_alu       <= w_div_res;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign pc_target_out = r_pc_target;
  assign pc4_out       = r_pc4;
  assign alu_out       = r_alu;
  assign rs2_out       = r_rs2;
  assign zero_out      = (r_alu == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ex_stage.sv
// tb_pipeline_ex_stage: directed stimulus with a spec-level result model and scoreboard.
// Rev 1.0
`default_nettype none

module tb_pipeline_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0, rs1_in = '0, rs2_in = '0, imm_in = '0;
  logic        alu_src_b_in = 1'b0;
  logic [3:0]  alu_ctrl_in = '0;
  logic        md_en_in = 1'b0;
  logic [2:0]  md_op_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] pc_target_out, pc4_out, alu_out, rs2_out;
  logic        zero_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ex_stage #(.XLEN(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .alu_src_b_in(alu_src_b_in), .alu_ctrl_in(alu_ctrl_in),
    .md_en_in(md_en_in), .md_op_in(md_op_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_target_out(pc_target_out), .pc4_out(pc4_out),
    .alu_out(alu_out), .rs2_out(rs2_out), .zero_out(zero_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- spec-level model ----------------
  typedef struct {
    logic [31:0] alu;
    logic [31:0] pt;
    logic [31:0] p4;
    logic [31:0] rs2;
  } exp_t;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return sa >>> b[4:0];
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0] p;
    int ia = a;
    int ib = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t model(input logic md, input logic [2:0] op, input logic [3:0] c,
                                 input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic srcb);
    exp_t e;
    e.pt  = pc + imm;
    e.p4  = pc + 32'd4;
    e.rs2 = b;
    e.alu = md ? md_model(op, a, b) : alu_model(c, a, srcb ? imm : b);
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t sb_q[$];
  exp_t held;
  bit   hold_v = 0;

  always @(negedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("stable_valid", {31'd0, out_valid}, 32'd1);
        chk("stable_alu", alu_out, held.alu);
        chk("stable_pct", pc_target_out, held.pt);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_alu", alu_out, e.alu);
          chk("sb_pc_target", pc_target_out, e.pt);
          chk("sb_pc4", pc4_out, e.p4);
          chk("sb_rs2", rs2_out, e.rs2);
          chk("sb_zero", {31'd0, zero_out}, {31'd0, e.alu == 32'd0});
        end
      end
      hold_v = out_valid && !out_ready && !flush;
      held.alu = alu_out;
      held.pt  = pc_target_out;
      if (flush) sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back(model(md_en_in, md_op_in, alu_ctrl_in, pc_in, rs1_in, rs2_in, imm_in, alu_src_b_in));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input string nm, input logic md, input logic [2:0] op, input logic [3:0] c,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic srcb, input logic rdy_before,
                       input logic rdy_after, input bit wait_res, input int exp_lat,
                       input logic [31:0] exp_alu);
    int n;
    @(posedge clk); #1;
    pc_in = pc; rs1_in = a; rs2_in = b; imm_in = imm; alu_src_b_in = srcb;
    alu_ctrl_in = c; md_en_in = md; md_op_in = op; out_ready = rdy_before; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = rdy_after;
    if (wait_res) begin
      n = 1;
      @(negedge clk);
      if (exp_lat > 1) chk({nm, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_result"}, alu_out, exp_alu);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_pc_target", pc_target_out, 32'd0);
    chk("rst_pc4", pc4_out, 32'd0);
    chk("rst_rs2", rs2_out, 32'd0);
    chk("rst_zero", {31'd0, zero_out}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // ALU back-to-back
    pc_in = 32'h100; imm_in = 32'h20; rs1_in = 32'd5; rs2_in = 32'd7; alu_src_b_in = 1'b0;
    alu_ctrl_in = 4'd0; md_en_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rs1_in = 32'd7; rs2_in = 32'd7; alu_ctrl_in = 4'd1;
    @(negedge clk);
    chk("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_add", alu_out, 32'd12);
    chk("b2b_pc_target", pc_target_out, 32'h120);
    chk("b2b_pc4", pc4_out, 32'h104);
    @(posedge clk); #1;
    rs1_in = 32'h8000_0000; imm_in = 32'd4; alu_src_b_in = 1'b1; alu_ctrl_in = 4'd7;
    @(negedge clk);
    chk("b2b_sub", alu_out, 32'd0);
    chk("b2b_sub_zero", {31'd0, zero_out}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sra", alu_out, 32'hF800_0000);
    chk("b2b_sra_valid", {31'd0, out_valid}, 32'd1);

    // more ALU codes
    issue("slt",    0, 0, 4'd3,  32'h10, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 1, 1, 1, 32'd1);
    issue("sltu",   0, 0, 4'd4,  32'h14, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 1, 1, 1, 32'd0);
    issue("sll_amt",0, 0, 4'd2,  32'h18, 32'd1, 32'd0, 32'h21, 1, 1, 1, 1, 1, 32'd2);
    issue("srl",    0, 0, 4'd6,  32'h1C, 32'h8000_0000, 32'd0, 32'd4, 1, 1, 1, 1, 1, 32'h0800_0000);
    issue("or",     0, 0, 4'd8,  32'h20, 32'hF0, 32'h0F, 0, 0, 1, 1, 1, 1, 32'hFF);
    issue("code12", 0, 0, 4'd12, 32'h24, 32'd9, 32'd3, 0, 0, 1, 1, 1, 1, 32'd0);

    // multiply
    issue("mulh",   1, 3'd1, 0, 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h99, 1, 1, 1, 1, 3, 32'd0);
    issue("mulhu",  1, 3'd3, 0, 32'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h99, 1, 1, 1, 1, 3, 32'hFFFF_FFFE);
    issue("mul",    1, 3'd0, 0, 32'h48, 32'hFFFF_FFFD, 32'd7, 32'd1, 1, 1, 1, 1, 3, 32'hFFFF_FFEB);
    issue("mulhsu", 1, 3'd2, 0, 32'h4C, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, 1, 1, 3, 32'hFFFF_FFFF);

    // divide
    issue("div",    1, 3'd4, 0, 32'h50, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 1, 1, 33, 32'hFFFF_FFFD);
    issue("rem",    1, 3'd6, 0, 32'h54, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 1, 1, 33, 32'hFFFF_FFFF);
    issue("divu0",  1, 3'd5, 0, 32'h58, 32'd7, 32'd0, 0, 0, 1, 1, 1, 33, 32'hFFFF_FFFF);
    issue("rem0",   1, 3'd6, 0, 32'h5C, 32'd7, 32'd0, 0, 0, 1, 1, 1, 33, 32'd7);
    issue("divovf", 1, 3'd4, 0, 32'h60, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 33, 32'h8000_0000);

    // backpressure: held ALU result, then DIV completing into a stalled slot
    issue("bp_add", 0, 0, 4'd0, 32'h70, 32'd3, 32'd4, 0, 0, 1, 0, 1, 1, 32'd7);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    issue("bp_div", 1, 3'd4, 0, 32'h74, 32'd100, 32'd7, 0, 0, 1, 0, 1, 33, 32'd14);
    repeat (3) @(negedge clk);
    chk("bp_div_held", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // flush mid-DIV
    issue("fl_div", 1, 3'd4, 0, 32'h80, 32'd1000, 32'd3, 0, 0, 1, 1, 0, 0, 32'd0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("fl_no_stale", {31'd0, seen}, 32'd0);
    issue("fl_add", 0, 0, 4'd0, 32'h90, 32'd1, 32'd1, 0, 0, 1, 1, 1, 1, 32'd2);

    // async reset mid-MUL
    issue("rs_mul", 1, 3'd0, 0, 32'h200, 32'd6, 32'd7, 32'h10, 0, 1, 1, 0, 0, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_alu", alu_out, 32'd0);
    chk("arst_pc_target", pc_target_out, 32'd0);
    chk("arst_pc4", pc4_out, 32'd0);
    chk("arst_rs2", rs2_out, 32'd0);
    chk("arst_zero", {31'd0, zero_out}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("arst_no_stale", {31'd0, seen}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
